// File: rtl/cmp_cache_pkg.sv
// Shared widths, beat layout and occupancy sizing for the compare->cache pipeline register.
package cmp_cache_pkg;

    localparam int CMP_CACHE_ADDR_W   = 32;
    localparam int CMP_CACHE_DATA_W   = 32;
    localparam int CMP_CACHE_RESULT_W = 109;

    // Default-width view of one beat; field order matches the packing used inside the pipe.
    typedef struct packed {
        logic [CMP_CACHE_ADDR_W-1:0]   r_addr;
        logic [CMP_CACHE_DATA_W-1:0]   r_data;
        logic                          hit;
        logic [CMP_CACHE_RESULT_W-1:0] result;
        logic                          req_valid;
        logic                          r_valid;
    } cmp_cache_beat_t;

    // Counter must reach STAGES+1 when the skid entry is present.
    function automatic int occ_w(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/cmp_cache_pipe_slot.sv
// One pipeline slot: a valid bit plus payload; flush beats fill, fill beats drain.
// Payload loads only on fill and is left as-is by flush and drain.
module cmp_cache_pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         fill,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dat
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            if (flush) begin
                vld <= 1'b0;
            end else if (fill) begin
                vld <= 1'b1;
            end else if (drain) begin
                vld <= 1'b0;
            end
            if (fill && !flush) begin
                dat <= din;
            end
        end
    end

endmodule

// File: rtl/cmp_cache_pipe_reg.sv
// Elastic STAGES-deep compare->cache register: a beat accepted on edge N heads the pipe after edge N+STAGES-1, 1 beat/cycle.
// Stalls ripple back from out_ready_i into in_ready_o; CMP_CACHE_SKID_BUFFER_EN adds a skid entry so in_ready_o is registered.
module cmp_cache_pipe_reg
    import cmp_cache_pkg::*;
#(
    parameter int ADDR_W   = CMP_CACHE_ADDR_W,
    parameter int DATA_W   = CMP_CACHE_DATA_W,
    parameter int RESULT_W = CMP_CACHE_RESULT_W,
    parameter int STAGES   = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ADDR_W-1:0]        in_r_addr_i,
    input  logic [DATA_W-1:0]        in_r_data_i,
    input  logic                     in_hit_i,
    input  logic [RESULT_W-1:0]      in_result_i,
    input  logic                     in_req_valid_i,
    input  logic                     in_r_valid_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDR_W-1:0]        out_r_addr_o,
    output logic [DATA_W-1:0]        out_r_data_o,
    output logic                     out_hit_o,
    output logic [RESULT_W-1:0]      out_result_o,
    output logic                     out_req_valid_o,
    output logic                     out_r_valid_o,
    output logic [occ_w(STAGES)-1:0] occupancy_o
);

    localparam int BEAT_W = ADDR_W + DATA_W + RESULT_W + 3;
    localparam int OCC_W  = occ_w(STAGES);
    localparam int HEAD   = STAGES - 1;

    typedef struct packed {
        logic [ADDR_W-1:0]   r_addr;
        logic [DATA_W-1:0]   r_data;
        logic                hit;
        logic [RESULT_W-1:0] result;
        logic                req_valid;
        logic                r_valid;
    } beat_t;

    beat_t             in_beat;
    beat_t             head_beat;
    logic [STAGES-1:0] stage_vld;
    logic [STAGES-1:0] stage_fill;
    logic [STAGES-1:0] stage_adv;
    logic [BEAT_W-1:0] stage_dat [STAGES];
    logic              src_vld;
    logic [BEAT_W-1:0] src_dat;
    logic              stage0_free;
    logic              in_acc;
    logic              out_acc;
    logic [OCC_W-1:0]  occ;

    assign in_beat = {in_r_addr_i, in_r_data_i, in_hit_i, in_result_i, in_req_valid_i, in_r_valid_i};

    // Advance is resolved head-first so a stall or a hole propagates toward stage 0 in one cycle.
    always_comb begin
        stage_adv       = '0;
        stage_adv[HEAD] = stage_vld[HEAD] && out_ready_i;
        for (int k = HEAD - 1; k >= 0; k--) begin
            stage_adv[k] = stage_vld[k] && (!stage_vld[k+1] || stage_adv[k+1]);
        end
    end

    assign stage0_free = !stage_vld[0] || stage_adv[0];

    always_comb begin
        stage_fill    = '0;
        stage_fill[0] = src_vld && stage0_free;
        for (int k = 1; k < STAGES; k++) begin
            stage_fill[k] = stage_adv[k-1];
        end
    end

`ifdef CMP_CACHE_SKID_BUFFER_EN
    logic              skid_vld;
    logic [BEAT_W-1:0] skid_dat;

    // A beat taken while stage 0 is blocked parks here; it always drains before any newer beat.
    cmp_cache_pipe_slot #(
        .W (BEAT_W)
    ) u_skid (
        .clk   (CLK),
        .reset (RESET),
        .flush (flush_i),
        .fill  (in_acc && !stage0_free),
        .drain (skid_vld && stage0_free),
        .din   (in_beat),
        .vld   (skid_vld),
        .dat   (skid_dat)
    );

    assign in_ready_o = !skid_vld;
    assign src_vld    = skid_vld || in_valid_i;
    assign src_dat    = skid_vld ? skid_dat : in_beat;
`else
    // Combinational from out_ready_i through the advance chain.
    assign in_ready_o = stage0_free;
    assign src_vld    = in_valid_i;
    assign src_dat    = in_beat;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [BEAT_W-1:0] din;
        if (k == 0) begin : g_first
            assign din = src_dat;
        end else begin : g_next
            assign din = stage_dat[k-1];
        end

        cmp_cache_pipe_slot #(
            .W (BEAT_W)
        ) u_slot (
            .clk   (CLK),
            .reset (RESET),
            .flush (flush_i),
            .fill  (stage_fill[k]),
            .drain (stage_adv[k]),
            .din   (din),
            .vld   (stage_vld[k]),
            .dat   (stage_dat[k])
        );
    end

    assign in_acc  = in_valid_i && in_ready_o;
    assign out_acc = stage_vld[HEAD] && out_ready_i;

    // A flushed head is not a transfer, so flush simply zeroes the count.
    always_ff @(posedge CLK) begin
        if (RESET || flush_i) begin
            occ <= '0;
        end else if (in_acc && !out_acc) begin
            occ <= occ + OCC_W'(1);
        end else if (!in_acc && out_acc) begin
            occ <= occ - OCC_W'(1);
        end
    end

    assign head_beat       = beat_t'(stage_dat[HEAD]);
    assign out_valid_o     = stage_vld[HEAD];
    assign out_r_addr_o    = head_beat.r_addr;
    assign out_r_data_o    = head_beat.r_data;
    assign out_hit_o       = head_beat.hit;
    assign out_result_o    = head_beat.result;
    assign out_req_valid_o = head_beat.req_valid;
    assign out_r_valid_o   = head_beat.r_valid;
    assign occupancy_o     = occ;

endmodule

// File: tb/tb_cmp_cache_pipe_reg.sv
// Directed bench: a STAGES=3 and a STAGES=2 instance share the input drive; each test selects one to score.
module tb_cmp_cache_pipe_reg;
    import cmp_cache_pkg::*;

`ifdef CMP_CACHE_SKID_BUFFER_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         rst, flush, in_vld, in_hit, in_reqv, in_rv, out_rdy;
    logic [31:0]  in_addr, in_data;
    logic [108:0] in_res;

    logic         a_in_rdy, a_ov, a_hit, a_reqv, a_rv;
    logic [31:0]  a_addr, a_data;
    logic [108:0] a_res;
    logic [2:0]   a_occ;
    logic         b_in_rdy, b_ov, b_hit, b_reqv, b_rv;
    logic [31:0]  b_addr, b_data;
    logic [108:0] b_res;
    logic [1:0]   b_occ;

    cmp_cache_pipe_reg #(.STAGES(3)) u_dut_a (
        .CLK(CLK), .RESET(rst), .flush_i(flush), .in_valid_i(in_vld), .in_ready_o(a_in_rdy),
        .in_r_addr_i(in_addr), .in_r_data_i(in_data), .in_hit_i(in_hit), .in_result_i(in_res),
        .in_req_valid_i(in_reqv), .in_r_valid_i(in_rv), .out_valid_o(a_ov), .out_ready_i(out_rdy),
        .out_r_addr_o(a_addr), .out_r_data_o(a_data), .out_hit_o(a_hit), .out_result_o(a_res),
        .out_req_valid_o(a_reqv), .out_r_valid_o(a_rv), .occupancy_o(a_occ)
    );

    cmp_cache_pipe_reg #(.STAGES(2)) u_dut_b (
        .CLK(CLK), .RESET(rst), .flush_i(flush), .in_valid_i(in_vld), .in_ready_o(b_in_rdy),
        .in_r_addr_i(in_addr), .in_r_data_i(in_data), .in_hit_i(in_hit), .in_result_i(in_res),
        .in_req_valid_i(in_reqv), .in_r_valid_i(in_rv), .out_valid_o(b_ov), .out_ready_i(out_rdy),
        .out_r_addr_o(b_addr), .out_r_data_o(b_data), .out_hit_o(b_hit), .out_result_o(b_res),
        .out_req_valid_o(b_reqv), .out_r_valid_o(b_rv), .occupancy_o(b_occ)
    );

    logic            use_b;
    logic            s_in_rdy, s_ov;
    logic [2:0]      s_occ;
    cmp_cache_beat_t s_beat, in_beat;

    assign in_beat  = {in_addr, in_data, in_hit, in_res, in_reqv, in_rv};
    assign s_beat   = use_b ? {b_addr, b_data, b_hit, b_res, b_reqv, b_rv}
                            : {a_addr, a_data, a_hit, a_res, a_reqv, a_rv};
    assign s_in_rdy = use_b ? b_in_rdy : a_in_rdy;
    assign s_ov     = use_b ? b_ov : a_ov;
    assign s_occ    = use_b ? {1'b0, b_occ} : a_occ;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic cmp_cache_beat_t mk(input logic [31:0] a);
        cmp_cache_beat_t b;
        b.r_addr    = a;
        b.r_data    = a ^ 32'h5A5A_0000;
        b.hit       = a[0];
        b.result    = {45'h0A5_C3D2_E1F0, ~a, a};
        b.req_valid = 1'b1;
        b.r_valid   = a[1];
        return b;
    endfunction

    task automatic set_beat(input logic [31:0] a);
        cmp_cache_beat_t b;
        b       = mk(a);
        in_addr = b.r_addr;
        in_data = b.r_data;
        in_hit  = b.hit;
        in_res  = b.result;
        in_reqv = b.req_valid;
        in_rv   = b.r_valid;
    endtask

    // Scoreboard: beats accepted in order must leave in order, bit-exact.
    cmp_cache_beat_t exp_q[$];
    cmp_cache_beat_t last_beat;
    bit              acc_in, acc_out;
    logic [2:0]      occ_pre;
    int              cyc = 0, cyc0 = 0, n_out = 0, n_dead = 0, first_out = -1, last_out = -1;

    task automatic step();
        @(negedge CLK);
        acc_in  = in_vld && s_in_rdy && !rst && !flush;
        acc_out = s_ov && out_rdy && !rst && !flush;
        occ_pre = s_occ;
        if (!rst && s_ov && s_beat.r_addr == 32'hDEAD) n_dead++;
        if (acc_out) begin
            check_eq("out_has_exp", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("out_beat", s_beat, exp_q.pop_front());
            if (n_out == 0) first_out = cyc - cyc0;
            last_out  = cyc - cyc0;
            last_beat = s_beat;
            n_out++;
        end
        if (acc_in) exp_q.push_back(in_beat);
        if (rst || flush) exp_q.delete();
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_vld = 1'b1; out_rdy = 1'b0;
        set_beat(32'h55);
        step();
        step();
        rst = 1'b0; in_vld = 1'b0;
    endtask

    logic [31:0] bub [3] = '{32'hA0, 32'hB0, 32'hC0};
    int          i, acc_last;
    bit          found;

    initial begin
        use_b = 1'b0;

        // Reset with a beat offered.
        rst = 1'b1; flush = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
        set_beat(32'h77);
        step();
        step();
        check_eq("rst_a_ov", a_ov, 0);
        check_eq("rst_a_occ", a_occ, 0);
        check_eq("rst_a_rdy", a_in_rdy, 1);
        check_eq("rst_a_res", a_res, 0);
        check_eq("rst_a_addr", a_addr, 0);
        check_eq("rst_b_ov", b_ov, 0);
        check_eq("rst_b_occ", b_occ, 0);
        check_eq("rst_b_rdy", b_in_rdy, 1);
        rst = 1'b0; in_vld = 1'b0;

        // Back-to-back stream through STAGES=3.
        use_b = 1'b0;
        do_reset();
        out_rdy = 1'b1; n_out = 0; i = 0; acc_last = -1; cyc0 = cyc;
        for (int c = 0; c < 40 && n_out < 16; c++) begin
            in_vld = (i < 16);
            set_beat(32'h100 + i);
            step();
            if (acc_in) begin
                i++;
                acc_last = c;
            end
        end
        in_vld = 1'b0;
        check_eq("stream_in", i, 16);
        check_eq("stream_in_last", acc_last, 15);
        check_eq("stream_out", n_out, 16);
        check_eq("stream_first", first_out, 3);
        check_eq("stream_last", last_out, 18);

        // Backpressure on STAGES=2.
        use_b = 1'b1;
        do_reset();
        out_rdy = 1'b0; n_out = 0; i = 0;
        for (int c = 0; c < 5; c++) begin
            in_vld = 1'b1;
            set_beat(32'h200 + i);
            step();
            if (acc_in) i++;
            if (c >= 2) check_eq("bp_head_hold", s_beat, mk(32'h200));
        end
        check_eq("bp_accepts", i, 2 + SKID);
        check_eq("bp_in_ready", s_in_rdy, 0);
        check_eq("bp_occ", s_occ, 2 + SKID);
        check_eq("bp_head_vld", s_ov, 1);
        out_rdy = 1'b1;
        for (int c = 0; c < 40 && n_out < 6; c++) begin
            in_vld = (i < 6);
            set_beat(32'h200 + i);
            step();
            if (acc_in) i++;
        end
        in_vld = 1'b0;
        check_eq("bp_drain_out", n_out, 6);
        check_eq("bp_drain_left", exp_q.size(), 0);

        // Bubble collapse on STAGES=3.
        use_b = 1'b0;
        do_reset();
        out_rdy = 1'b0; n_out = 0; i = 0;
        for (int c = 0; c < 6; c++) begin
            in_vld = (c % 2 == 0);
            set_beat(bub[(i > 2) ? 2 : i]);
            step();
            if (acc_in) i++;
            check_eq("bub_occ", s_occ, c / 2 + 1);
        end
        in_vld = 1'b0;
        check_eq("bub_head_vld", s_ov, 1);
        check_eq("bub_head", s_beat.r_addr, 32'hA0);
        out_rdy = 1'b1;
        for (int c = 0; c < 20 && n_out < 3; c++) step();
        check_eq("bub_out", n_out, 3);
        check_eq("bub_occ_end", s_occ, 0);

        // Flush with a valid head, out_ready high and a new offer.
        use_b = 1'b0;
        do_reset();
        out_rdy = 1'b0; n_out = 0; n_dead = 0;
        for (int c = 0; c < 3; c++) begin
            in_vld = (c < 2);
            set_beat(32'h300 + c);
            step();
        end
        check_eq("fl_occ_pre", s_occ, 2);
        check_eq("fl_head_pre", s_ov, 1);
        in_vld = 1'b1; set_beat(32'hDEAD); flush = 1'b1; out_rdy = 1'b1;
        step();
        flush = 1'b0; in_vld = 1'b0;
        check_eq("fl_vld", s_ov, 0);
        check_eq("fl_occ", s_occ, 0);
        check_eq("fl_rdy", s_in_rdy, 1);
        for (int c = 0; c < 8; c++) step();
        check_eq("fl_out", n_out, 0);
        check_eq("fl_dead", n_dead, 0);

        // Full, then in and out accepted together; sideband hit=1 r_valid=0.
        use_b = 1'b1;
        do_reset();
        out_rdy = 1'b0; n_out = 0; i = 0; found = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_vld = 1'b1;
            set_beat(32'h401 + 4 * i);
            step();
            if (acc_in) i++;
        end
        check_eq("sim_fill_occ", s_occ, 2 + SKID);
        check_eq("sim_fill_rdy", s_in_rdy, 0);
        out_rdy = 1'b1;
        for (int c = 0; c < 30 && (i < 6 || exp_q.size() != 0); c++) begin
            in_vld = (i < 6);
            set_beat(32'h401 + 4 * i);
            step();
            if (acc_in) i++;
            if (acc_in && acc_out && !found) begin
                found = 1'b1;
                check_eq("sim_occ_hold", s_occ, occ_pre);
                check_eq("sim_occ_full", occ_pre, 2);
            end
        end
        in_vld = 1'b0;
        check_eq("sim_found", found, 1);
        check_eq("sim_out", n_out, 6);
        check_eq("sb_hit", last_beat.hit, 1);
        check_eq("sb_rv", last_beat.r_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
